// File: rtl/test_pattern_gen_pkg.sv
// Shared types for the test pattern generator: pattern modes and FSM states.
package test_pattern_gen_pkg;

    // Pattern select codes as seen on the mode input.
    typedef enum logic [2:0] {
        ModeZero  = 3'd0,
        ModeOnes  = 3'd1,
        ModeUser  = 3'd2,
        ModeCount = 3'd3,
        ModeWalk1 = 3'd4,
        ModeWalk0 = 3'd5,
        ModeLfsr  = 3'd6,
        ModeRsvd  = 3'd7
    } tp_mode_e;

    // Run-control FSM states.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } tp_state_e;

    localparam int unsigned ModeW = 3;

endpackage

// File: rtl/test_pattern_gen_next_value.sv
// Combinational pattern rules: first beat of a run and the step to the next beat.
module test_pattern_gen_next_value
    import test_pattern_gen_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] LFSR_POLY = WIDTH'('hB8)
) (
    input  tp_mode_e         mode_i,
    input  logic [WIDTH-1:0] cur_i,
    input  logic [WIDTH-1:0] const_i,
    output logic [WIDTH-1:0] first_o,
    output logic [WIDTH-1:0] next_o
);

    localparam logic [WIDTH-1:0] OneHotLsb = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] rot_left;
    logic [WIDTH-1:0] lfsr_step;

    // Shared datapath pieces for the walking and LFSR modes.
    always_comb begin
        rot_left  = {cur_i[WIDTH-2:0], cur_i[WIDTH-1]};
        lfsr_step = cur_i[0] ? ((cur_i >> 1) ^ LFSR_POLY) : (cur_i >> 1);
    end

    // First beat loaded when a run starts.
    always_comb begin
        first_o = '0;
        unique case (mode_i)
            ModeZero:  first_o = '0;
            ModeOnes:  first_o = '1;
            ModeUser:  first_o = const_i;
            ModeCount: first_o = const_i;
            ModeWalk1: first_o = OneHotLsb;
            ModeWalk0: first_o = ~OneHotLsb;
            // An all-zero seed would lock the LFSR up, so force it to 1.
            ModeLfsr:  first_o = (const_i == '0) ? OneHotLsb : const_i;
            default:   first_o = '0;
        endcase
    end

    // Next beat after the current one is accepted.
    always_comb begin
        next_o = '0;
        unique case (mode_i)
            ModeZero:  next_o = '0;
            ModeOnes:  next_o = '1;
            ModeUser:  next_o = cur_i;
            ModeCount: next_o = cur_i + OneHotLsb;
            ModeWalk1: next_o = rot_left;
            ModeWalk0: next_o = rot_left;
            ModeLfsr:  next_o = lfsr_step;
            default:   next_o = '0;
        endcase
    end

endmodule

// File: rtl/test_pattern_gen.sv
// Test pattern generator: emits num_beats patterns over valid/ready, then pulses done.
module test_pattern_gen
    import test_pattern_gen_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      CNT_W     = 16,
    parameter logic [WIDTH-1:0] LFSR_POLY = WIDTH'('hB8)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] const_val,
    input  logic [CNT_W-1:0] num_beats,
    input  logic             ready,
    output logic [WIDTH-1:0] pattern,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] beat_cnt
);

    tp_state_e        state_q, state_d;
    tp_mode_e         mode_q, mode_d;
    logic [CNT_W-1:0] nbeats_q, nbeats_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [WIDTH-1:0] pattern_q, pattern_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    tp_mode_e         mode_sel;
    logic [WIDTH-1:0] first_val;
    logic [WIDTH-1:0] next_val;
    logic [CNT_W-1:0] beat_cnt_inc;
    logic             accept;
    logic             last_beat;

    // In IDLE the rules see the incoming mode so the first beat can be loaded on start.
    always_comb begin
        mode_sel     = (state_q == StIdle) ? tp_mode_e'(mode) : mode_q;
        accept       = valid_q && ready;
        beat_cnt_inc = beat_cnt_q + CNT_W'(1);
        // num_beats of 0 falls out naturally: the counter wraps to 0 on beat 2^CNT_W.
        last_beat    = (beat_cnt_inc == nbeats_q);
    end

    test_pattern_gen_next_value #(
        .WIDTH    (WIDTH),
        .LFSR_POLY(LFSR_POLY)
    ) u_next_value (
        .mode_i (mode_sel),
        .cur_i  (pattern_q),
        .const_i(const_val),
        .first_o(first_val),
        .next_o (next_val)
    );

    // Next-state logic for the run FSM, handshake and beat counter.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        nbeats_d   = nbeats_q;
        beat_cnt_d = beat_cnt_q;
        pattern_d  = pattern_q;
        valid_d    = valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                if (start) begin
                    mode_d     = tp_mode_e'(mode);
                    nbeats_d   = num_beats;
                    pattern_d  = first_val;
                    beat_cnt_d = '0;
                    state_d    = StRun;
                    valid_d    = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            StRun: begin
                valid_d = 1'b1;
                busy_d  = 1'b1;
                if (accept) begin
                    pattern_d  = next_val;
                    beat_cnt_d = beat_cnt_inc;
                    if (last_beat) begin
                        state_d = StDone;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = StIdle;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

        // Abort wins over start and over a same-cycle handshake; that beat is dropped.
        if (abort) begin
            state_d    = StIdle;
            mode_d     = mode_q;
            nbeats_d   = nbeats_q;
            beat_cnt_d = beat_cnt_q;
            pattern_d  = pattern_q;
            valid_d    = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            mode_q     <= ModeZero;
            nbeats_q   <= '0;
            beat_cnt_q <= '0;
            pattern_q  <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            nbeats_q   <= nbeats_d;
            beat_cnt_q <= beat_cnt_d;
            pattern_q  <= pattern_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Drive ports straight from flops.
    always_comb begin
        pattern  = pattern_q;
        valid    = valid_q;
        busy     = busy_q;
        done     = done_q;
        beat_cnt = beat_cnt_q;
    end

endmodule

// File: tb/tb_test_pattern_gen.sv
// Scoreboard bench for test_pattern_gen (WIDTH=8, CNT_W=16, poly 0xB8).
module tb_test_pattern_gen;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [2:0]  mode;
    logic [7:0]  const_val;
    logic [15:0] num_beats;
    logic        ready;
    logic [7:0]  pattern;
    logic        valid;
    logic        busy;
    logic        done;
    logic [15:0] beat_cnt;

    int total;
    int bad;
    logic [7:0] exp_q[$];

    test_pattern_gen dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .mode     (mode),
        .const_val(const_val),
        .num_beats(num_beats),
        .ready    (ready),
        .pattern  (pattern),
        .valid    (valid),
        .busy     (busy),
        .done     (done),
        .beat_cnt (beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model of the pattern rules.
    function automatic logic [7:0] model_first(input logic [2:0] m, input logic [7:0] c);
        case (m)
            3'd1:    return 8'hFF;
            3'd2:    return c;
            3'd3:    return c;
            3'd4:    return 8'h01;
            3'd5:    return 8'hFE;
            3'd6:    return (c == 8'h00) ? 8'h01 : c;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] model_next(input logic [2:0] m, input logic [7:0] x);
        logic [7:0] s;
        case (m)
            3'd1:    return 8'hFF;
            3'd2:    return x;
            3'd3:    return 8'((int'(x) + 1) % 256);
            3'd4, 3'd5: return 8'((int'(x) * 2) % 256) | {7'd0, x[7]};
            3'd6: begin
                s = {1'b0, x[7:1]};
                if (x[0]) s = s ^ 8'hB8;
                return s;
            end
            default: return 8'h00;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full run: expected beats go to the scoreboard at start, popped on each handshake.
    task automatic run_beats(input logic [2:0] m, input logic [7:0] c, input logic [15:0] n,
                             input logic [15:0] rmask);
        logic [7:0] v;
        int acc;
        int idx;
        int cyc;
        v = model_first(m, c);
        for (int i = 0; i < int'(n); i++) begin
            exp_q.push_back(v);
            v = model_next(m, v);
        end
        mode      = m;
        const_val = c;
        num_beats = n;
        ready     = 1'b0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        acc = 0;
        idx = 0;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 200) begin
            ready = rmask[idx[3:0]];
            idx++;
            check_eq("valid", 32'(valid), 32'd1);
            check_eq("busy", 32'(busy), 32'd1);
            check_eq("pattern", 32'(pattern), 32'(exp_q[0]));
            check_eq("beat_cnt", 32'(beat_cnt), 32'(acc));
            check_eq("done_early", 32'(done), 32'd0);
            if (ready) begin
                void'(exp_q.pop_front());
                acc++;
            end
            tick();
            cyc++;
        end
        ready = 1'b0;
        if (cyc >= 200) begin
            check_eq("run_timeout", 32'(cyc), 32'd0);
            exp_q.delete();
        end
        check_eq("done_pulse", 32'(done), 32'd1);
        check_eq("valid_end", 32'(valid), 32'd0);
        check_eq("busy_end", 32'(busy), 32'd0);
        check_eq("beat_cnt_end", 32'(beat_cnt), 32'(n));
        tick();
        check_eq("done_one_cycle", 32'(done), 32'd0);
        check_eq("beat_cnt_hold", 32'(beat_cnt), 32'(n));
        tick();
    endtask

    initial begin
        logic [7:0] v;
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        mode      = 3'd0;
        const_val = 8'h00;
        num_beats = 16'd0;
        ready     = 1'b0;
        tick();
        check_eq("rst_pattern", 32'(pattern), 32'd0);
        check_eq("rst_valid", 32'(valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_beat_cnt", 32'(beat_cnt), 32'd0);
        rst = 1'b0;
        tick();

        run_beats(3'd3, 8'hFE, 16'd4, 16'hFFFF);   // COUNT wrapping through 00
        run_beats(3'd4, 8'h00, 16'd9, 16'hFFFF);   // WALK1 full rotation
        run_beats(3'd6, 8'h00, 16'd6, 16'hFFFF);   // LFSR with zero seed
        run_beats(3'd2, 8'h5A, 16'd3, 16'h0019);   // USER with ready 1,0,0,1,1
        run_beats(3'd5, 8'h00, 16'd3, 16'h5555);   // WALK0 with gaps
        run_beats(3'd1, 8'h12, 16'd2, 16'hFFFF);   // ONES
        run_beats(3'd7, 8'h77, 16'd2, 16'hFFFF);   // reserved acts as ZERO
        run_beats(3'd3, 8'h10, 16'd1, 16'hFFFF);   // single beat

        // Reset in the middle of a COUNT run after 5 accepted beats.
        mode      = 3'd3;
        const_val = 8'h20;
        num_beats = 16'd20;
        start     = 1'b1;
        tick();
        start = 1'b0;
        ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check_eq("pre_rst_cnt", 32'(beat_cnt), 32'd5);
        check_eq("pre_rst_pattern", 32'(pattern), 32'h25);
        rst = 1'b1;
        #1;
        check_eq("midrst_pattern", 32'(pattern), 32'd0);
        check_eq("midrst_valid", 32'(valid), 32'd0);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_beat_cnt", 32'(beat_cnt), 32'd0);
        tick();
        check_eq("midrst_done", 32'(done), 32'd0);
        ready = 1'b0;
        rst   = 1'b0;
        tick();
        check_eq("post_rst_done", 32'(done), 32'd0);
        check_eq("post_rst_valid", 32'(valid), 32'd0);

        // Abort on beat 3 with ready high; a start seen in RUN must be ignored.
        mode      = 3'd3;
        const_val = 8'h40;
        num_beats = 16'd10;
        start     = 1'b1;
        tick();
        start = 1'b0;
        v = model_first(3'd3, 8'h40);
        check_eq("ab_first", 32'(pattern), 32'(v));
        ready = 1'b1;
        tick();
        v = model_next(3'd3, v);
        check_eq("ab_beat1_cnt", 32'(beat_cnt), 32'd1);
        start     = 1'b1;
        const_val = 8'h99;
        tick();
        start = 1'b0;
        v = model_next(3'd3, v);
        check_eq("ignored_start_cnt", 32'(beat_cnt), 32'd2);
        check_eq("ignored_start_pat", 32'(pattern), 32'(v));
        check_eq("ignored_start_valid", 32'(valid), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        ready = 1'b0;
        check_eq("abort_valid", 32'(valid), 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_cnt", 32'(beat_cnt), 32'd2);
        check_eq("abort_pattern", 32'(pattern), 32'(v));
        check_eq("abort_done", 32'(done), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("abort_no_done", 32'(done), 32'd0);
            check_eq("abort_idle_valid", 32'(valid), 32'd0);
        end

        // Fresh run after abort still works.
        run_beats(3'd3, 8'hFF, 16'd2, 16'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the bench always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
